set_assoc_tag_lookup: RTL and testbench
=======================================

Name: set_assoc_tag_lookup

Overview:
- Parametrised successor to the current way-lookup contract. Adds an internal set-indexed tag/valid store with NUM_SETS sets of NUM_WAYS ways.
- Registered lookup with valid/ready handshake, fill port, and sequential flush (invalidate-all) state machine.
- Sits between the cache controller (address in, hit/miss out) and the eviction policy, which snoops the response.

Parameters:
- NUM_WAYS, 4, ways per set; power of two, >= 2.
- NUM_SETS, 4, sets; power of two, >= 2.
- ADDRESS_WIDTH, 32, request address width.
- BLOCK_SIZE, 32, bytes per block; OFFSET_WIDTH = $clog2(BLOCK_SIZE).
- Derived: INDEX_WIDTH = $clog2(NUM_SETS); TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH; WAY_IDX_WIDTH = $clog2(NUM_WAYS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- reqValid  in  1  lookup request valid.
- reqReady  out  1  lookup request accepted when reqValid && reqReady at clock edge.
- reqAddr  in  ADDRESS_WIDTH  lookup address. Fields: [OFFSET_WIDTH-1:0] offset (ignored), next INDEX_WIDTH bits set, upper TAG_WIDTH bits tag.
- respValid  out  1  response valid.
- respReady  in  1  consumer ready.
- hit  out  1  response hit.
- miss  out  1  response miss.
- hitWay  out  NUM_WAYS  one-hot hit way.
- hitWayIdx  out  WAY_IDX_WIDTH  encoded hit way.
- respSet  out  INDEX_WIDTH  set of the response.
- fillValid  in  1  write tag into way.
- fillReady  out  1  fill accepted.
- fillSet  in  INDEX_WIDTH  fill set.
- fillWay  in  WAY_IDX_WIDTH  fill way.
- fillTag  in  TAG_WIDTH  fill tag; sets valid.
- flushReq  in  1  start invalidate-all; single-cycle pulse.
- flushBusy  out  1  flush in progress.
- flushDone  out  1  one-cycle pulse at flush completion.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All valid bits 0; tags don't-care.
  - respValid, hit, miss, hitWay, hitWayIdx, respSet, flushBusy, flushDone all 0.
  - FSM in IDLE; set counter 0.
- Handshake and latency:
  - reqReady = (state==IDLE) && (!respValid || respReady).
  - Request accepted at edge N produces a response registered at edge N; it is visible in cycle N+1 with latency 1.
  - Response held stable while respValid && !respReady.
  - Back-to-back throughput is one request per cycle when respReady is high.
- Compare:
  - hitWay[w] = valid[set][w] && (tag[set][w] == reqTag).
  - hit = |hitWay; miss = !hit; both are 0 whenever respValid is 0.
  - hitWayIdx is the lowest set bit of hitWay; 0 on miss.
- Fill:
  - fillReady = (state==IDLE).
  - On accept, the tag is written and valid[fillSet][fillWay] is set at the edge.
  - Fill and lookup to the same set in the same cycle use write-first ordering: the lookup compares against post-fill contents.
  - A fill to an already-valid way overwrites it.
- Flush FSM:
  - IDLE: flushReq moves to FLUSH, counter = 0, flushBusy = 1. Requests and fills are blocked (ready low).
  - FLUSH: each cycle clears all valid bits of set[counter] and increments the counter. After clearing set NUM_SETS-1, move to DONE. Takes exactly NUM_SETS cycles.
  - DONE: flushDone = 1 for one cycle, flushBusy = 0, return to IDLE.
  - flushReq while not in IDLE is ignored.
  - A flushReq in the same cycle as an accepted request: the request is accepted because reqReady was high that cycle. The flush starts at the same edge. The response is still delivered and compares pre-flush contents.
  - A pending response in the output register is unaffected by a flush and is drained normally.
- Reset mid-flush or mid-stall returns all state to reset values immediately; no flushDone is emitted.

Optional Feature:
- Macro: SET_ASSOC_MULTI_HIT_DETECT_EN.
- Defined:
  - Adds output port multiHit (1 bit), registered with the response.
  - multiHit = respValid && ($countones(hitWay) > 1); reset 0.
  - hitWay still reports every matching way.
  - hitWayIdx stays at the lowest matching index.
  - A simulation-only assertion fires on multiHit.
- Undefined: no multiHit port; duplicate matches are silently resolved to the lowest index.

Test Plan (NUM_SETS=4, NUM_WAYS=4, ADDRESS_WIDTH=32, BLOCK_SIZE=32; TAG_WIDTH=25):
- Reset, then lookup 0x0000_1040 (set 2, tag 0x20) -> next cycle respValid=1, miss=1, hit=0, hitWay=0000, respSet=2.
- Fill set 2 way 3 tag 0x20, then lookup 0x0000_1040 -> hit=1, hitWay=1000, hitWayIdx=3. Lookup 0x0000_1060 (set 3) -> miss=1.
- Fill set 1 way 0 tag 0x7 in the same cycle as a lookup of 0x0000_03A0 (set 1, tag 0x7) -> hit=1, hitWay=0001 (write-first).
- Hold respReady=0 for 3 cycles after a response -> respValid and hit fields stable, reqReady=0. Release -> next request accepted the same cycle.
- After filling all 16 ways, pulse flushReq -> flushBusy high 4 cycles, reqReady=0 and fillReady=0 throughout, then flushDone pulses once. Every subsequent lookup misses.
- Assert rst_n low on the 2nd flush cycle -> flushBusy=0 immediately, no flushDone pulse, all prior tags miss.

Source files
------------

// File: rtl/set_assoc_tag_lookup.sv
// Set-associative tag/valid store with a registered hit/miss lookup, a fill port and
// a sequential invalidate-all flush. Optional multi-hit flag: SET_ASSOC_MULTI_HIT_DETECT_EN.

module set_assoc_way_cmp #(
  parameter int TAG_WIDTH = 25
) (
  input  logic                 vld,
  input  logic [TAG_WIDTH-1:0] tag,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 match
);
  assign match = vld && (tag == req_tag);
endmodule

module set_assoc_tag_lookup #(
  parameter int NUM_WAYS      = 4,
  parameter int NUM_SETS      = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 32,
  localparam int OFFSET_WIDTH  = $clog2(BLOCK_SIZE),
  localparam int INDEX_WIDTH   = $clog2(NUM_SETS),
  localparam int TAG_WIDTH     = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int WAY_IDX_WIDTH = $clog2(NUM_WAYS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [ADDRESS_WIDTH-1:0] reqAddr,
  output logic                     respValid,
  input  logic                     respReady,
  output logic                     hit,
  output logic                     miss,
  output logic [NUM_WAYS-1:0]      hitWay,
  output logic [WAY_IDX_WIDTH-1:0] hitWayIdx,
  output logic [INDEX_WIDTH-1:0]   respSet,
`ifdef SET_ASSOC_MULTI_HIT_DETECT_EN
  output logic                     multiHit,
`endif
  input  logic                     fillValid,
  output logic                     fillReady,
  input  logic [INDEX_WIDTH-1:0]   fillSet,
  input  logic [WAY_IDX_WIDTH-1:0] fillWay,
  input  logic [TAG_WIDTH-1:0]     fillTag,
  input  logic                     flushReq,
  output logic                     flushBusy,
  output logic                     flushDone
);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t                 state, state_nxt;
  logic [INDEX_WIDTH-1:0] flush_cnt;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]                valid;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_WIDTH-1:0] tags;

  logic [INDEX_WIDTH-1:0]   req_set;
  logic [TAG_WIDTH-1:0]     req_tag;
  logic                     req_acc, fill_acc, fill_same_set;
  logic [NUM_WAYS-1:0]      match;
  logic [WAY_IDX_WIDTH-1:0] match_idx;
  logic                     unused_offset;

  assign req_set       = reqAddr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag       = reqAddr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign unused_offset = ^reqAddr[OFFSET_WIDTH-1:0];

  assign reqReady  = (state == IDLE) && (!respValid || respReady);
  assign fillReady = (state == IDLE);
  assign flushBusy = (state == FLUSH);
  assign flushDone = (state == DONE);
  assign req_acc   = reqValid && reqReady;
  assign fill_acc  = fillValid && fillReady;
  assign fill_same_set = fill_acc && (fillSet == req_set);

  // Write-first: a fill landing in the looked-up set this cycle is bypassed into the compare.
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic                 byp;
    logic                 eff_vld;
    logic [TAG_WIDTH-1:0] eff_tag;
    assign byp     = fill_same_set && (fillWay == WAY_IDX_WIDTH'(w));
    assign eff_vld = byp || valid[req_set][w];
    assign eff_tag = byp ? fillTag : tags[req_set][w];
    set_assoc_way_cmp #(.TAG_WIDTH(TAG_WIDTH)) u_cmp (
      .vld    (eff_vld),
      .tag    (eff_tag),
      .req_tag(req_tag),
      .match  (match[w])
    );
  end

  always_comb begin
    match_idx = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (match[w]) match_idx = WAY_IDX_WIDTH'(w);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flushReq) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == INDEX_WIDTH'(NUM_SETS-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  // Fills are blocked outside IDLE, so flush clearing and fill setting never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (state == FLUSH) begin
      valid[flush_cnt] <= '0;
    end else if (fill_acc) begin
      valid[fillSet][fillWay] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_acc) tags[fillSet][fillWay] <= fillTag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      respValid <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      hitWay    <= '0;
      hitWayIdx <= '0;
      respSet   <= '0;
`ifdef SET_ASSOC_MULTI_HIT_DETECT_EN
      multiHit  <= 1'b0;
`endif
    end else if (req_acc) begin
      respValid <= 1'b1;
      hit       <= |match;
      miss      <= ~|match;
      hitWay    <= match;
      hitWayIdx <= match_idx;
      respSet   <= req_set;
`ifdef SET_ASSOC_MULTI_HIT_DETECT_EN
      multiHit  <= ($countones(match) > 1);
`endif
    end else if (respReady) begin
      respValid <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      hitWay    <= '0;
      hitWayIdx <= '0;
      respSet   <= '0;
`ifdef SET_ASSOC_MULTI_HIT_DETECT_EN
      multiHit  <= 1'b0;
`endif
    end
  end

`ifdef SET_ASSOC_MULTI_HIT_DETECT_EN
  a_no_multi_hit: assert property (@(posedge clk) disable iff (!rst_n) !multiHit)
    else $error("duplicate tag match in set %0d, ways %b", respSet, hitWay);
`endif

endmodule

// File: tb/tb_set_assoc_tag_lookup.sv
// Randomized + directed bench for set_assoc_tag_lookup against a plain array/counter model.

module tb_set_assoc_tag_lookup;
  localparam int NW = 4, NS = 4, AW = 32, BS = 32;
  localparam int OW = 5, IW = 2, TW = 25, WW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reqValid, reqReady, respValid, respReady;
  logic [AW-1:0] reqAddr;
  logic          hit, miss;
  logic [NW-1:0] hitWay;
  logic [WW-1:0] hitWayIdx;
  logic [IW-1:0] respSet;
  logic          fillValid, fillReady;
  logic [IW-1:0] fillSet;
  logic [WW-1:0] fillWay;
  logic [TW-1:0] fillTag;
  logic          flushReq, flushBusy, flushDone;
`ifdef SET_ASSOC_MULTI_HIT_DETECT_EN
  logic          multiHit;
`endif

  always #5 clk = ~clk;

  set_assoc_tag_lookup #(.NUM_WAYS(NW), .NUM_SETS(NS), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
    .respValid(respValid), .respReady(respReady),
    .hit(hit), .miss(miss), .hitWay(hitWay), .hitWayIdx(hitWayIdx), .respSet(respSet),
`ifdef SET_ASSOC_MULTI_HIT_DETECT_EN
    .multiHit(multiHit),
`endif
    .fillValid(fillValid), .fillReady(fillReady), .fillSet(fillSet), .fillWay(fillWay),
    .fillTag(fillTag),
    .flushReq(flushReq), .flushBusy(flushBusy), .flushDone(flushDone)
  );

  // Model state: plain arrays plus a flush position (-1 idle, 0..NS-1 clearing that set, NS done).
  bit            mv[NS][NW];
  logic [TW-1:0] mt[NS][NW];
  bit            m_rv;
  logic [NW-1:0] m_hw;
  int            m_idx, m_set, fc;

  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) mv[s][w] = 0;
    m_rv = 0; m_hw = '0; m_idx = 0; m_set = 0; fc = -1;
  endtask

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit idle, areq;
    int s;
    logic [TW-1:0] t;
    idle = (fc < 0);
    areq = reqValid && idle && (!m_rv || respReady);
    if (fillValid && idle) begin
      mv[fillSet][fillWay] = 1;
      mt[fillSet][fillWay] = fillTag;
    end
    if (areq) begin
      s = int'(reqAddr[OW +: IW]);
      t = reqAddr[AW-1 -: TW];
      m_hw = '0;
      for (int w = 0; w < NW; w++) if (mv[s][w] && mt[s][w] == t) m_hw[w] = 1'b1;
      m_idx = 0;
      for (int w = NW-1; w >= 0; w--) if (m_hw[w]) m_idx = w;
      m_rv = 1; m_set = s;
    end else if (respReady) begin
      m_rv = 0; m_hw = '0;
    end
    if (fc >= 0 && fc < NS) begin
      for (int w = 0; w < NW; w++) mv[fc][w] = 0;
      fc++;
    end else if (fc == NS) fc = -1;
    else if (idle && flushReq) fc = 0;
  endtask

  task automatic check_outputs();
    chk("respValid", 64'(respValid), 64'(m_rv));
    chk("hit", 64'(hit), 64'(m_rv && (m_hw != 0)));
    chk("miss", 64'(miss), 64'(m_rv && (m_hw == 0)));
    if (m_rv) begin
      chk("hitWay", 64'(hitWay), 64'(m_hw));
      chk("hitWayIdx", 64'(hitWayIdx), 64'(m_idx));
      chk("respSet", 64'(respSet), 64'(m_set));
    end
    chk("flushBusy", 64'(flushBusy), 64'(fc >= 0 && fc < NS));
    chk("flushDone", 64'(flushDone), 64'(fc == NS));
  endtask

  // Called at a negedge with inputs driven; ends at the next negedge with outputs checked.
  task automatic step();
    #1;
    chk("reqReady", 64'(reqReady), 64'((fc < 0) && (!m_rv || respReady)));
    chk("fillReady", 64'(fillReady), 64'(fc < 0));
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_in();
    reqValid = 0; reqAddr = '0; respReady = 1;
    fillValid = 0; fillSet = '0; fillWay = '0; fillTag = '0; flushReq = 0;
  endtask

  task automatic lookup(input logic [AW-1:0] a);
    idle_in(); reqValid = 1; reqAddr = a; step(); idle_in();
  endtask

  task automatic fill(input int s, input int w, input logic [TW-1:0] t);
    idle_in(); fillValid = 1; fillSet = IW'(s); fillWay = WW'(w); fillTag = t; step(); idle_in();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n;
    idle_in();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    chk("rst hitWayIdx", 64'(hitWayIdx), 64'(0));
    chk("rst respSet", 64'(respSet), 64'(0));
    rst_n = 1;

    // Cold miss, then fill and hit; set 2 tag 0x20.
    lookup(32'h0000_1040);
    chk("cold miss", 64'(miss), 64'(1));
    chk("cold hitWay", 64'(hitWay), 64'(0));
    chk("cold respSet", 64'(respSet), 64'(2));
    fill(2, 3, 25'h20);
    lookup(32'h0000_1040);
    chk("fill hit", 64'(hit), 64'(1));
    chk("fill hitWay", 64'(hitWay), 64'(4'b1000));
    chk("fill hitWayIdx", 64'(hitWayIdx), 64'(3));
    lookup(32'h0000_1060);
    chk("set3 miss", 64'(miss), 64'(1));
    chk("set3 respSet", 64'(respSet), 64'(3));

    // Fill and lookup to set 1 in the same cycle.
    idle_in();
    fillValid = 1; fillSet = 2'd1; fillWay = 2'd0; fillTag = 25'h7;
    reqValid = 1; reqAddr = 32'h0000_03A0;
    step(); idle_in();
    chk("wf hit", 64'(hit), 64'(1));
    chk("wf hitWay", 64'(hitWay), 64'(4'b0001));

    // Back-pressure hold for 3 cycles, then release with a waiting request.
    lookup(32'h0000_1040);
    reqValid = 1; reqAddr = 32'h0000_1060; respReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall reqReady", 64'(reqReady), 64'(0));
      step();
      chk("stall respValid", 64'(respValid), 64'(1));
      chk("stall hitWay", 64'(hitWay), 64'(4'b1000));
    end
    respReady = 1;
    #1 chk("release reqReady", 64'(reqReady), 64'(1));
    step(); idle_in();
    chk("release miss", 64'(miss), 64'(1));
    chk("release respSet", 64'(respSet), 64'(3));

    // Fill all 16 ways, flush, and confirm everything misses.
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) fill(s, w, TW'(25'h100 + s*4 + w));
    flushReq = 1; step(); idle_in();
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (flushBusy) begin
        busy_n++;
        chk("flush reqReady", 64'(reqReady), 64'(0));
        chk("flush fillReady", 64'(fillReady), 64'(0));
      end
      if (flushDone) done_n++;
      step();
    end
    chk("flush busy cycles", 64'(busy_n), 64'(4));
    chk("flush done pulses", 64'(done_n), 64'(1));
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        lookup({TW'(25'h100 + s*4 + w), IW'(s), OW'(0)});
        chk("post-flush miss", 64'(miss), 64'(1));
      end

    // Random traffic with a narrow tag space so hits and duplicate matches happen.
    for (int i = 0; i < 3000; i++) begin
      reqValid  = ($urandom_range(0, 3) != 0);
      reqAddr   = {TW'($urandom_range(0, 3)), IW'($urandom), OW'($urandom)};
      respReady = ($urandom_range(0, 3) != 0);
      fillValid = ($urandom_range(0, 2) == 0);
      fillSet   = IW'($urandom);
      fillWay   = WW'($urandom);
      fillTag   = TW'($urandom_range(0, 3));
      flushReq  = ($urandom_range(0, 60) == 0);
      step();
    end
    idle_in();
    repeat (8) step();

    // Reset asserted on the second flush cycle.
    fill(0, 0, 25'h55);
    fill(3, 2, 25'h66);
    flushReq = 1; step(); idle_in();
    step();
    rst_n = 0;
    #1;
    chk("midflush rst flushBusy", 64'(flushBusy), 64'(0));
    chk("midflush rst flushDone", 64'(flushDone), 64'(0));
    chk("midflush rst respValid", 64'(respValid), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    lookup({25'h55, 2'd0, 5'd0});
    chk("after rst miss0", 64'(miss), 64'(1));
    lookup({25'h66, 2'd3, 5'd0});
    chk("after rst miss3", 64'(miss), 64'(1));
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
